// File: rtl/apb_pkg.sv
// apb_pkg: constants and types shared by the APB register-file responder.
//   APB_ADDR_W / APB_DATA_W : default bus widths
//   APB_BASE_ADDR           : default byte address of register 0
//   APB_ID_VALUE            : default contents of the read-only ID register
//   apb_state_e             : transfer FSM states
//   cnt_width()             : width of the wait-state down-counter
package apb_pkg;

    localparam int          APB_ADDR_W    = 32;
    localparam int          APB_DATA_W    = 32;
    localparam logic [31:0] APB_BASE_ADDR = 32'h8000_0000;
    localparam logic [31:0] APB_ID_VALUE  = 32'hA9B0_0001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } apb_state_e;

    // The counter must hold WAIT_STATES itself; zero-wait builds still get one bit.
    function automatic int cnt_width(input int ws);
        return (ws < 1) ? 1 : $clog2(ws + 1);
    endfunction

endpackage

// File: rtl/apb_slave_regfile_if.sv
// apb_slave_regfile_if: APB completer-side bus bundle.
//   psel, penable, pwrite, paddr, pwdata : driven by the bridge (master)
//   prdata, pready, pslverr              : driven by the responder (slave)
interface apb_slave_regfile_if
    import apb_pkg::*;
#(
    parameter int ADDR_W = APB_ADDR_W,
    parameter int DATA_W = APB_DATA_W
);

    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );

endinterface

// File: rtl/apb_slave_regfile_regs.sv
// apb_slave_regs: register storage, address decode and error classification.
//   hclk, hreset       : clock, asynchronous active-high reset (clears RW regs)
//   rd_addr, rd_write  : access being decoded this cycle
//   rd_data            : combinational read data (0 on error)
//   rd_err             : access is illegal (below base, out of range, misaligned, ID write)
//   rd_idx             : decoded word index, reused by the caller as the write index
//   wr_en, wr_idx, wr_data : synchronous full-word write port
// The last word is the read-only ID register and has no storage.
module apb_slave_regs
    import apb_pkg::*;
#(
    parameter int                ADDR_W    = APB_ADDR_W,
    parameter int                DATA_W    = APB_DATA_W,
    parameter int                NUM_REGS  = 8,
    parameter int                IDX_W     = 3,
    parameter logic [ADDR_W-1:0] BASE_ADDR = APB_BASE_ADDR,
    parameter logic [DATA_W-1:0] ID_VALUE  = APB_ID_VALUE
) (
    input  logic              hclk,
    input  logic              hreset,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_write,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_err,
    output logic [IDX_W-1:0]  rd_idx,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data
);

    logic [DATA_W-1:0] mem [NUM_REGS-1];
    logic [ADDR_W-1:0] offset;
    logic [ADDR_W-1:0] word;
    logic              below;
    logic              out_of_range;
    logic              misaligned;
    logic              is_id;

    always_comb begin
        // Underflow is caught by the explicit compare; the wrapped offset is then don't-care.
        offset       = rd_addr - BASE_ADDR;
        word         = offset >> 2;
        below        = (rd_addr < BASE_ADDR);
        out_of_range = (word >= ADDR_W'(NUM_REGS));
        misaligned   = |rd_addr[1:0];
        rd_idx       = word[IDX_W-1:0];
        is_id        = (rd_idx == IDX_W'(NUM_REGS - 1));
        rd_err       = below | out_of_range | misaligned | (rd_write & is_id);
        rd_data      = '0;
        if (!rd_err) begin
            if (is_id) begin
                rd_data = ID_VALUE;
            end else begin
                for (int i = 0; i < NUM_REGS - 1; i++) begin
                    if (rd_idx == IDX_W'(i)) begin
                        // Forward a write committing this edge so a read set up in the
                        // same cycle never sees the stale word.
                        rd_data = (wr_en && (wr_idx == rd_idx)) ? wr_data : mem[i];
                    end
                end
            end
        end
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            for (int i = 0; i < NUM_REGS - 1; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            for (int i = 0; i < NUM_REGS - 1; i++) begin
                if (wr_idx == IDX_W'(i)) begin
                    mem[i] <= wr_data;
                end
            end
        end
    end

endmodule

// File: rtl/apb_slave_regfile.sv
// apb_slave_regfile: APB responder serving a small 32-bit register file with
// programmable wait states.
//   hclk   : clock, rising edge
//   hreset : asynchronous active-high reset
//   bus    : APB slave modport (psel/penable/pwrite/paddr/pwdata in,
//            prdata/pready/pslverr out, all outputs registered)
// A transfer takes 2+WAIT_STATES cycles; pready is high for exactly one cycle
// (the DONE state) and a write commits at the edge that ends that cycle.
module apb_slave_regfile
    import apb_pkg::*;
#(
    parameter int                ADDR_W      = APB_ADDR_W,
    parameter int                DATA_W      = APB_DATA_W,
    parameter int                NUM_REGS    = 8,
    parameter int                WAIT_STATES = 1,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = APB_BASE_ADDR,
    parameter logic [DATA_W-1:0] ID_VALUE    = APB_ID_VALUE
) (
    input  logic                hclk,
    input  logic                hreset,
    apb_slave_regfile_if.slave  bus
);

    localparam int             IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int             CNT_W     = cnt_width(WAIT_STATES);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_STATES);
    localparam bit             ZERO_WAIT = (WAIT_STATES == 0);

    apb_state_e        state;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] addr_p0;
    logic              write_p0;
    logic [DATA_W-1:0] wdata_p0;
    logic              wr_en_p1;
    logic [IDX_W-1:0]  wr_idx_p1;
    logic [DATA_W-1:0] prdata_r;
    logic              pready_r;
    logic              pslverr_r;

    logic              setup;
    logic              in_wait;
    logic              enter_done;
    logic [ADDR_W-1:0] dec_addr;
    logic              dec_write;
    logic [DATA_W-1:0] rd_data;
    logic              rd_err;
    logic [IDX_W-1:0]  rd_idx;

    always_comb begin
        setup   = bus.psel & ~bus.penable;
        in_wait = (state == WAIT);
        // While waiting, decode the request latched at setup; otherwise the
        // bus itself, since a zero-wait setup completes on the very next edge.
        dec_addr  = in_wait ? addr_p0  : bus.paddr;
        dec_write = in_wait ? write_p0 : bus.pwrite;
        enter_done = (!in_wait && setup && ZERO_WAIT) ||
                     (in_wait && bus.psel && bus.penable && (cnt == CNT_W'(1)));
    end

    apb_slave_regs #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .NUM_REGS  (NUM_REGS),
        .IDX_W     (IDX_W),
        .BASE_ADDR (BASE_ADDR),
        .ID_VALUE  (ID_VALUE)
    ) u_regs (
        .hclk     (hclk),
        .hreset   (hreset),
        .rd_addr  (dec_addr),
        .rd_write (dec_write),
        .rd_data  (rd_data),
        .rd_err   (rd_err),
        .rd_idx   (rd_idx),
        .wr_en    (wr_en_p1),
        .wr_idx   (wr_idx_p1),
        .wr_data  (wdata_p0)
    );

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state     <= IDLE;
            cnt       <= '0;
            addr_p0   <= '0;
            write_p0  <= 1'b0;
            wdata_p0  <= '0;
            wr_en_p1  <= 1'b0;
            wr_idx_p1 <= '0;
            prdata_r  <= '0;
            pready_r  <= 1'b0;
            pslverr_r <= 1'b0;
        end else begin
            // setup -> access/wait: latch request, arm counter
            unique case (state)
                IDLE, DONE: begin
                    if (setup) begin
                        addr_p0  <= bus.paddr;
                        write_p0 <= bus.pwrite;
                        wdata_p0 <= bus.pwdata;
                        cnt      <= CNT_INIT;
                        state    <= ZERO_WAIT ? DONE : WAIT;
                    end else begin
                        state <= IDLE;
                    end
                end
                WAIT: begin
                    if (!bus.psel) begin
                        state <= IDLE;
                    end else if (bus.penable) begin
                        if (cnt == CNT_W'(1)) begin
                            state <= DONE;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            // completion: outputs and the pending write are valid only in DONE
            pready_r  <= enter_done;
            pslverr_r <= enter_done & rd_err;
            prdata_r  <= (enter_done && !dec_write) ? rd_data : '0;
            wr_en_p1  <= enter_done & dec_write & ~rd_err;
            if (enter_done) begin
                wr_idx_p1 <= rd_idx;
            end
        end
    end

    assign bus.prdata  = prdata_r;
    assign bus.pready  = pready_r;
    assign bus.pslverr = pslverr_r;

endmodule

// File: tb/tb_apb_slave_regfile.sv
module tb_apb_slave_regfile;

    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam logic [31:0] IDV  = 32'hA9B0_0001;

    logic hclk = 1'b0;
    logic hreset;
    always #5 hclk = ~hclk;

    apb_slave_regfile_if bus0 ();
    apb_slave_regfile_if bus1 ();

    // dut0: zero-wait build, dut1: one wait state
    apb_slave_regfile #(.WAIT_STATES(0)) dut0 (.hclk(hclk), .hreset(hreset), .bus(bus0));
    apb_slave_regfile #(.WAIT_STATES(1)) dut1 (.hclk(hclk), .hreset(hreset), .bus(bus1));

    int checks   = 0;
    int failures = 0;
    logic [31:0] model [2][8];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int w, input logic s, input logic e, input logic wr,
                         input logic [31:0] a, input logic [31:0] d);
        if (w == 0) begin
            bus0.psel = s; bus0.penable = e; bus0.pwrite = wr; bus0.paddr = a; bus0.pwdata = d;
        end else begin
            bus1.psel = s; bus1.penable = e; bus1.pwrite = wr; bus1.paddr = a; bus1.pwdata = d;
        end
    endtask

    task automatic idle(input int w);
        drive(w, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    function automatic logic get_ready(input int w);
        return (w == 0) ? bus0.pready : bus1.pready;
    endfunction
    function automatic logic get_err(input int w);
        return (w == 0) ? bus0.pslverr : bus1.pslverr;
    endfunction
    function automatic logic [31:0] get_rdata(input int w);
        return (w == 0) ? bus0.prdata : bus1.prdata;
    endfunction

    function automatic int ws_of(input int w);
        return (w == 0) ? 0 : 1;
    endfunction

    // Reference decode straight from the address map rules.
    function automatic logic exp_err(input logic wr, input logic [31:0] a);
        longint unsigned ua;
        longint unsigned off;
        ua = 64'(a);
        if (ua < 64'(BASE)) return 1'b1;
        off = ua - 64'(BASE);
        if (off % 4 != 0) return 1'b1;
        if (off / 4 >= 8) return 1'b1;
        if (wr && (off / 4 == 7)) return 1'b1;
        return 1'b0;
    endfunction

    // Starts one cycle after a posedge; returns one cycle after the posedge
    // that ends the pready cycle, with the bus still in its access phase.
    task automatic xfer(input int w, input logic wr, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic err, output int cyc);
        bit done;
        rd = 32'h0; err = 1'b0; done = 0;
        drive(w, 1'b1, 1'b0, wr, a, d);
        cyc = 1;
        @(posedge hclk); #1;
        drive(w, 1'b1, 1'b1, wr, a, d);
        cyc = 2;
        while (!done) begin
            @(negedge hclk);
            if (get_ready(w)) begin
                done = 1;
            end else if (cyc >= 20) begin
                checks++;
                failures++;
                $error("FAIL xfer_timeout observed=%0d cycles expected=%0d", cyc, 2 + ws_of(w));
                done = 1;
            end else begin
                @(posedge hclk); #1;
                cyc++;
            end
        end
        rd  = get_rdata(w);
        err = get_err(w);
        @(posedge hclk); #1;
    endtask

    task automatic do_op(input int w, input logic wr, input logic [31:0] a, input logic [31:0] d,
                         input bit b2b, input string tag);
        logic [31:0] rd;
        logic        err;
        int          cyc;
        logic        e_err;
        int          idx;
        e_err = exp_err(wr, a);
        idx   = int'((a - BASE) >> 2);
        xfer(w, wr, a, d, rd, err, cyc);
        check({tag, "_cycles"}, 32'(cyc), 32'(2 + ws_of(w)));
        check({tag, "_pslverr"}, {31'h0, err}, {31'h0, e_err});
        if (!wr) begin
            if (e_err)        check({tag, "_prdata"}, rd, 32'h0);
            else if (idx == 7) check({tag, "_prdata"}, rd, IDV);
            else              check({tag, "_prdata"}, rd, model[w][idx]);
        end
        if (wr && !e_err) model[w][idx] = d;
        if (!b2b) begin
            idle(w);
            @(negedge hclk);
            check({tag, "_pready_low"}, {31'h0, get_ready(w)}, 32'h0);
            @(posedge hclk); #1;
        end
    endtask

    function automatic logic [31:0] rand_addr();
        int k;
        k = int'($urandom_range(0, 6));
        case (k)
            0, 1, 2, 3: return BASE + 32'(4 * $urandom_range(0, 7));
            4:          return BASE + 32'(4 * $urandom_range(8, 15));
            5:          return BASE + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(1, 3));
            default:    return BASE - 32'(4 * $urandom_range(1, 4));
        endcase
    endfunction

    task automatic random_ops(input int n);
        for (int k = 0; k < n; k++) begin
            int w;
            w = int'($urandom_range(0, 1));
            do_op(w, 1'($urandom_range(0, 1)), rand_addr(), $urandom(), bit'($urandom_range(0, 1)),
                  (w == 0) ? "rnd_ws0" : "rnd_ws1");
            idle(w);
        end
    endtask

    task automatic zero_models();
        for (int w = 0; w < 2; w++)
            for (int i = 0; i < 8; i++)
                model[w][i] = 32'h0;
    endtask

    initial begin
        hreset = 1'b1;
        idle(0);
        idle(1);
        zero_models();

        // Reset state
        repeat (3) @(posedge hclk);
        @(negedge hclk);
        check("rst_pready0",  {31'h0, bus0.pready},  32'h0);
        check("rst_pslverr0", {31'h0, bus0.pslverr}, 32'h0);
        check("rst_prdata0",  bus0.prdata,           32'h0);
        check("rst_pready1",  {31'h0, bus1.pready},  32'h0);
        check("rst_pslverr1", {31'h0, bus1.pslverr}, 32'h0);
        check("rst_prdata1",  bus1.prdata,           32'h0);
        @(posedge hclk); #1;
        hreset = 1'b0;
        @(posedge hclk); #1;

        // Write/readback with one wait state
        do_op(1, 1'b1, BASE + 32'h4, 32'hDEAD_BEEF, 0, "t2_wr");
        do_op(1, 1'b0, BASE + 32'h4, 32'h0,         0, "t2_rd");

        // Zero-wait back-to-back writes then reads
        for (int i = 0; i < 7; i++) do_op(0, 1'b1, BASE + 32'(4 * i), $urandom(), 1, "t3_wr");
        for (int i = 0; i < 7; i++) do_op(0, 1'b0, BASE + 32'(4 * i), 32'h0, 1, "t3_rd");
        idle(0);
        @(posedge hclk); #1;

        // Error accesses on both builds
        for (int w = 0; w < 2; w++) begin
            do_op(w, 1'b0, BASE + 32'h20, 32'h0,         0, "t4_rd_idx8");
            do_op(w, 1'b0, BASE + 32'h2,  32'h0,         0, "t4_rd_misal");
            do_op(w, 1'b1, BASE + 32'h1C, 32'h1234_5678, 0, "t4_wr_id");
            do_op(w, 1'b0, BASE - 32'h4,  32'h0,         0, "t4_rd_below");
            do_op(w, 1'b0, BASE + 32'h1C, 32'h0,         0, "t4_rd_id");
        end

        // Abort during WAIT
        do_op(1, 1'b1, BASE + 32'h8, 32'h5A5A_0002, 0, "t5_pre");
        drive(1, 1'b1, 1'b0, 1'b1, BASE + 32'h8, 32'hFFFF_0000);
        @(posedge hclk); #1;
        idle(1);
        for (int i = 0; i < 4; i++) begin
            @(negedge hclk);
            check("t5_abort_pready", {31'h0, bus1.pready}, 32'h0);
        end
        @(posedge hclk); #1;
        do_op(1, 1'b0, BASE + 32'h8, 32'h0, 0, "t5_rd");

        // Stray penable with no setup
        drive(1, 1'b1, 1'b1, 1'b0, BASE + 32'h4, 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge hclk);
            check("t6_stray_pready", {31'h0, bus1.pready}, 32'h0);
        end
        @(posedge hclk); #1;
        idle(1);
        @(posedge hclk); #1;
        do_op(1, 1'b0, BASE + 32'h4, 32'h0, 0, "t6_rd");

        // Randomized traffic against the model
        random_ops(60);
        @(posedge hclk); #1;

        // Reset mid-WAIT drops the write
        do_op(1, 1'b1, BASE + 32'h4, 32'hAAAA_5555, 0, "t1_pre");
        drive(1, 1'b1, 1'b0, 1'b1, BASE + 32'h4, 32'h1234_5678);
        @(posedge hclk); #1;
        drive(1, 1'b1, 1'b1, 1'b1, BASE + 32'h4, 32'h1234_5678);
        #1 hreset = 1'b1;
        #1;
        check("t1_wait_pready",  {31'h0, bus1.pready},  32'h0);
        check("t1_wait_pslverr", {31'h0, bus1.pslverr}, 32'h0);
        check("t1_wait_prdata",  bus1.prdata,           32'h0);
        idle(1);
        idle(0);
        @(posedge hclk); #1;
        hreset = 1'b0;
        zero_models();
        @(posedge hclk); #1;
        do_op(1, 1'b0, BASE + 32'h4, 32'h0, 0, "t1_rd_after");

        // Reset while pready is high clears outputs immediately
        drive(1, 1'b1, 1'b0, 1'b0, BASE + 32'h1C, 32'h0);
        @(posedge hclk); #1;
        drive(1, 1'b1, 1'b1, 1'b0, BASE + 32'h1C, 32'h0);
        @(posedge hclk); #1;
        @(negedge hclk);
        check("t1_done_pready", {31'h0, bus1.pready}, 32'h1);
        check("t1_done_prdata", bus1.prdata,          IDV);
        #1 hreset = 1'b1;
        #1;
        check("t1_async_pready", {31'h0, bus1.pready}, 32'h0);
        check("t1_async_prdata", bus1.prdata,          32'h0);
        idle(1);
        @(posedge hclk); #1;
        hreset = 1'b0;
        zero_models();
        @(posedge hclk); #1;

        random_ops(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
